pattern_matcher: RTL and testbench
==================================

PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning pattern length in bits (min 2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-003 SHALL have parameter DEF_PAT, default 8'b10110110 (PAT_W bits), meaning the pattern loaded at reset.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port valid, input, 1, meaning bit_in is sampled this cycle.
REQ-007 SHALL have port bit_in, input, 1, meaning the serial data bit.
REQ-008 SHALL have port cfg_load, input, 1, meaning load the pattern and mask and restart the search.
REQ-009 SHALL have port cfg_pattern, input, PAT_W, meaning the pattern; the MSB is the first bit expected.
REQ-010 SHALL have port cfg_mask, input, PAT_W, meaning a 1 bit compares that position and a 0 bit is don't-care.
REQ-011 SHALL have port overlap_en, input, 1, meaning 1 for overlapping detection and 0 for non-overlapping.
REQ-012 SHALL have port clear_cnt, input, 1, meaning clear match_count.
REQ-013 SHALL have port bit_out, output, 1, meaning a one-cycle pulse per detected match.
REQ-014 SHALL have port match_count, output, CNT_W, meaning the saturating number of matches.

Function
REQ-015 SHALL keep a PAT_W-bit shift register that shifts left with bit_in entering the LSB, only in cycles with valid=1; cycles with valid=0 leave all state unchanged apart from the bit_out deassertion.
REQ-016 SHALL evaluate a match as ((sh_next XOR pat_r) AND mask_r) == 0, where sh_next is the shift register including the current bit.
REQ-017 SHALL run a two-state FSM: FILL, which counts valid bits with fill_cnt from 0 to PAT_W-1, and DETECT, in which every valid bit is a match candidate.
REQ-018 SHALL go from FILL to DETECT on the valid bit that makes PAT_W bits received; that bit SHALL itself be a match candidate.
REQ-019 SHALL, after a match with overlap_en=1, stay in DETECT.
REQ-020 SHALL, after a match with overlap_en=0, go to FILL with fill_cnt=0, so that the next match needs PAT_W fresh bits.
REQ-021 SHALL drive bit_out as a registered output: it is 1 in the cycle after the clock edge that sampled the completing bit, and 0 otherwise.
REQ-022 SHALL produce back-to-back bit_out pulses when consecutive valid bits each complete an overlapping match.
REQ-023 SHALL increment match_count by 1 per match and SHALL saturate it at 2^CNT_W-1.
REQ-024 SHALL, on cfg_load=1, latch cfg_pattern and cfg_mask into pat_r and mask_r, clear the shift register and fill_cnt, go to FILL, and discard any bit valid in the same cycle (no match, bit_out=0 next cycle).
REQ-025 SHALL leave match_count unchanged on cfg_load.
REQ-026 SHALL, on clear_cnt=1 together with a match in the same cycle, give match_count=1 (clear first, then count).
REQ-027 SHALL, on clear_cnt=1 with no match in the same cycle, give match_count=0.
REQ-028 SHALL, with mask_r all zeros, match on every valid bit once PAT_W bits have been received.
REQ-029 SHALL sample overlap_en on the matching cycle, so that changing it mid-stream affects only later matches.

Reset
REQ-030 SHALL, with reset=1 at a clock edge, set bit_out=0, match_count=0, shift register=0, fill_cnt=0, state=FILL, pat_r=DEF_PAT and mask_r=all ones.
REQ-031 SHALL give reset priority over cfg_load, clear_cnt and valid.
REQ-032 SHALL, on reset mid-pattern, discard partial progress, so that a full PAT_W fresh bits are needed afterwards.

Verification
REQ-033 SHALL cover: after reset, stream 10110110 with valid=1 -> bit_out=1 exactly one cycle after the 8th bit, match_count=1, no earlier pulse.
REQ-034 SHALL cover: stream 10110110110110 with overlap_en=1 -> pulses after bits 8, 11 and 14, count=3; the same stream with overlap_en=0 -> pulse after bit 8 only, count=1.
REQ-035 SHALL cover: 10110110 with valid=0 gaps of 1-3 cycles and random bit_in during the gaps -> a single pulse after the 8th valid bit, count=1.
REQ-036 SHALL cover: cfg_load pattern=11110000, mask=11110000, then stream 1111 0101 -> a match after the 8th bit; stream 1110 0000 -> no match.
REQ-037 SHALL cover: 5 bits of 10110110, then cfg_load with DEF_PAT plus valid in the same cycle, then the full 8 bits -> exactly one pulse, after the final 8 bits only.
REQ-038 SHALL cover: CNT_W=2 with 5 overlapping matches -> count=3 held; clear_cnt on a match cycle -> count=1; reset asserted while bit_out=1 -> bit_out=0 and count=0 next cycle.

Source files
------------

// File: rtl/pattern_matcher.sv
// Serial bit-pattern detector with a per-bit don't-care mask.
// Supports overlapping and non-overlapping detection, plus a saturating match counter.
module pattern_matcher #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b10110110)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             bit_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             overlap_en,
  input  logic             clear_cnt,
  output logic             bit_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  localparam logic [0:0] S_FILL   = 1'b0;
  localparam logic [0:0] S_DETECT = 1'b1;

  logic [0:0]       r_state;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] r_sh;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_mask;
  logic             r_bit_out;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_sh_next;
  logic             w_last;
  logic             w_cand;
  logic             w_match;

  // A bit is a candidate once PAT_W bits are in since the last restart;
  // a bit arriving together with cfg_load is dropped.
  always_comb begin
    w_sh_next = {r_sh[PAT_W-2:0], bit_in};
    w_last    = (r_fill == FW'(PAT_W - 1));
    w_cand    = valid && !cfg_load
                && ((r_state == S_DETECT) || w_last);
    w_match   = w_cand
                && (((w_sh_next ^ r_pat) & r_mask) == '0);
  end

  // Shift register, fill counter, FSM, configuration and pulse output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FILL;
      r_fill    <= '0;
      r_sh      <= '0;
      r_pat     <= DEF_PAT;
      r_mask    <= '1;
      r_bit_out <= 1'b0;
    end else begin
      r_bit_out <= w_match;
      if (cfg_load) begin
        r_pat   <= cfg_pattern;
        r_mask  <= cfg_mask;
        r_sh    <= '0;
        r_fill  <= '0;
        r_state <= S_FILL;
      end else if (valid) begin
        r_sh <= w_sh_next;
        if (w_match && !overlap_en) begin
          r_state <= S_FILL;
          r_fill  <= '0;
        end else if (r_state == S_FILL) begin
          if (w_last) begin
            r_state <= S_DETECT;
          end else begin
            r_fill <= r_fill + FW'(1);
          end
        end
      end
    end
  end

  // Saturating match counter; a clear in a match cycle still counts that match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear_cnt) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_out     = r_bit_out;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_pattern_matcher.sv
// Bench for pattern_matcher: a queue-based reference model is checked every cycle,
// and directed scenarios are pinned with hand-computed values.
module tb_pattern_matcher;

  logic       clk = 1'b0;
  logic       reset, valid, bit_in, cfg_load, overlap_en, clear_cnt;
  logic [7:0] cfg_pattern, cfg_mask;
  logic       o8, o2;
  logic [7:0] c8;
  logic [1:0] c2;

  int nerr = 0;
  int nchk = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  pattern_matcher u_dut8 (
    .clk(clk), .reset(reset), .valid(valid), .bit_in(bit_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .overlap_en(overlap_en), .clear_cnt(clear_cnt),
    .bit_out(o8), .match_count(c8)
  );

  pattern_matcher #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .valid(valid), .bit_in(bit_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .overlap_en(overlap_en), .clear_cnt(clear_cnt),
    .bit_out(o2), .match_count(c2)
  );

  // Reference model: window of the last 8 bits since restart, compared
  // position by position with the pattern (MSB = oldest bit).
  bit         q[$];
  int         nb;
  logic [7:0] m_pat, m_mask;
  bit         m_out, hit;
  int         m_cnt8, m_cnt2;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      nb = 0;
      m_pat = 8'b10110110;
      m_mask = 8'hFF;
      m_out = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      hit = 0;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_mask = cfg_mask;
        q.delete();
        nb = 0;
      end else if (valid) begin
        q.push_back(bit_in);
        if (q.size() > 8) void'(q.pop_front());
        nb++;
        if (nb >= 8) begin
          hit = 1;
          for (int i = 0; i < 8; i++)
            if (m_mask[7-i] && (q[i] != m_pat[7-i])) hit = 0;
          if (hit && !overlap_en) nb = 0;
        end
      end
      m_out = hit;
      if (clear_cnt) begin
        m_cnt8 = hit ? 1 : 0;
        m_cnt2 = hit ? 1 : 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: outputs are registered, so check them mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("bit_out8", {31'd0, o8}, {31'd0, m_out});
      chk("bit_out2", {31'd0, o2}, {31'd0, m_out});
      chk("count8", {24'd0, c8}, m_cnt8);
      chk("count2", {30'd0, c2}, m_cnt2);
    end
  end

  task automatic step(input bit v, input bit b);
    valid = v;
    bit_in = b;
    @(negedge clk);
    valid = 0;
    cfg_load = 0;
    clear_cnt = 0;
    reset = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step(0, 0);
  endtask

  task automatic send(input logic [31:0] d, input int n, input bit gaps,
                      output logic [31:0] pv);
    logic [31:0] dd;
    dd = d;
    pv = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(1, 3);
        for (int k = 0; k < g; k++) step(0, 1'($urandom));
      end
      step(1, dd[n-1-i]);
      pv = {pv[30:0], o8};
    end
  endtask

  logic [31:0] pv;

  initial begin
    reset = 1; valid = 0; bit_in = 0; cfg_load = 0;
    overlap_en = 1; clear_cnt = 0;
    cfg_pattern = 8'b10110110; cfg_mask = 8'hFF;
    @(negedge clk);
    do_reset();
    chk_on = 1;
    chk("rst_out", {31'd0, o8}, 0);
    chk("rst_cnt", {24'd0, c8}, 0);

    send(32'b10110110, 8, 0, pv);
    chk("basic_pv", pv, 32'h1);
    chk("basic_cnt", {24'd0, c8}, 1);

    do_reset();
    overlap_en = 1;
    send(32'b10110110110110, 14, 0, pv);
    chk("ovl_pv", pv, 32'h49);
    chk("ovl_cnt", {24'd0, c8}, 3);

    do_reset();
    overlap_en = 0;
    send(32'b10110110110110, 14, 0, pv);
    chk("novl_pv", pv, 32'h40);
    chk("novl_cnt", {24'd0, c8}, 1);

    do_reset();
    send(32'b10110110, 8, 1, pv);
    chk("gap_pv", pv, 32'h1);
    chk("gap_cnt", {24'd0, c8}, 1);

    do_reset();
    cfg_pattern = 8'hF0; cfg_mask = 8'hF0; cfg_load = 1;
    step(0, 0);
    send(32'b11110101, 8, 0, pv);
    chk("mask_hit", pv, 32'h1);
    send(32'b11100000, 8, 0, pv);
    chk("mask_miss", pv, 32'h0);

    do_reset();
    overlap_en = 1;
    send(32'b10110, 5, 0, pv);
    chk("load_part", pv, 32'h0);
    cfg_pattern = 8'b10110110; cfg_mask = 8'hFF; cfg_load = 1;
    step(1, 1);
    chk("load_drop", {31'd0, o8}, 0);
    send(32'b10110110, 8, 0, pv);
    chk("load_pv", pv, 32'h1);

    do_reset();
    send(32'b10110110110110110110, 20, 0, pv);
    chk("sat_pv", pv, 32'h1249);
    chk("sat_cnt2", {30'd0, c2}, 3);
    chk("sat_cnt8", {24'd0, c8}, 5);
    send(32'b11, 2, 0, pv);
    clear_cnt = 1;
    step(1, 0);
    chk("clr_hit_out", {31'd0, o8}, 1);
    chk("clr_hit_cnt2", {30'd0, c2}, 1);
    chk("clr_hit_cnt8", {24'd0, c8}, 1);
    clear_cnt = 1;
    step(0, 0);
    chk("clr_idle", {24'd0, c8}, 0);
    send(32'b110, 3, 0, pv);
    chk("pre_rst_out", {31'd0, o8}, 1);
    reset = 1;
    step(1, 1);
    chk("rst_pulse_out", {31'd0, o8}, 0);
    chk("rst_pulse_cnt", {24'd0, c8}, 0);
    send(32'b0110110, 7, 0, pv);
    chk("rst_fresh", pv, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) begin
        cfg_load = 1;
        cfg_pattern = 8'($urandom);
        cfg_mask = ($urandom_range(0, 3) == 0) ? 8'h00
                   : 8'($urandom & $urandom);
      end
      if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
      clear_cnt = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom));
    end

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
